// File: rtl/unidad_busqueda.sv
// MIPS32 instruction fetch: PC register, next-PC mux, IF/ID register and one-entry skid buffer.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap to EXC_VECTOR.
module unidad_busqueda #(
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  fuente_pc,
    input  logic [31:0] dir_rama,
    input  logic [31:0] dir_salto,
    input  logic [31:0] dir_reg,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4,
    output logic        id_valid,
    output logic        excepcion
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } estado_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_t;

    estado_t     r_estado, w_estado_sig;
    logic [31:0] r_pc, w_pc_sig;
    logic [31:0] r_sq_addr, w_sq_addr_sig;
    logic        r_squash, w_squash_sig;
    ifid_t       r_ifid, w_ifid_sig;
    ifid_t       r_skid, w_skid_sig;
    logic        r_ifid_vld, w_ifid_vld_sig;
    logic        r_skid_vld, w_skid_vld_sig;
    ifid_t       w_nuevo;
    logic        w_redir;
    logic        w_xfer;
    logic [31:0] w_target;
    logic [31:0] w_dest;
    logic [31:0] w_pc4;

    assign w_redir = (fuente_pc != 2'b00);
    assign w_xfer  = imem_req & imem_ack;
    assign w_pc4   = r_pc + 32'd4;
    assign w_nuevo = '{instr: imem_rdata, pc4: w_pc4};

    always_comb begin
        case (fuente_pc)
            2'b01:   w_target = dir_rama;
            2'b10:   w_target = dir_salto;
            default: w_target = dir_reg;
        endcase
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic w_misalign;
    logic r_exc;

    assign w_misalign = (w_target[1:0] != 2'b00);
    assign w_dest     = w_misalign ? EXC_VECTOR : w_target;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_exc <= 1'b0;
        else        r_exc <= w_redir & w_misalign;
    end

    assign excepcion = r_exc;
`else
    assign w_dest    = w_target & 32'hFFFF_FFFC;
    assign excepcion = 1'b0;
`endif

    // While a squashed request is still in flight the bus must keep its old address;
    // r_pc already holds the redirect target for the request that follows.
    assign imem_req  = (r_estado == S_FETCH);
    assign imem_addr = r_squash ? r_sq_addr : r_pc;
    assign id_instr  = r_ifid.instr;
    assign id_pc4    = r_ifid.pc4;
    assign id_valid  = r_ifid_vld;

    always_comb begin
        w_estado_sig   = r_estado;
        w_pc_sig       = r_pc;
        w_sq_addr_sig  = r_sq_addr;
        w_squash_sig   = r_squash;
        w_ifid_sig     = r_ifid;
        w_ifid_vld_sig = r_ifid_vld;
        w_skid_sig     = r_skid;
        w_skid_vld_sig = r_skid_vld;

        if (r_ifid_vld && !stall) w_ifid_vld_sig = 1'b0;

        case (r_estado)
            S_IDLE: w_estado_sig = S_FETCH;
            S_FETCH: begin
                if (w_xfer) begin
                    if (r_squash) begin
                        w_squash_sig = 1'b0;
                    end else begin
                        w_pc_sig = w_pc4;
                        if (!r_ifid_vld || !stall) begin
                            w_ifid_sig     = w_nuevo;
                            w_ifid_vld_sig = 1'b1;
                        end else begin
                            w_skid_sig     = w_nuevo;
                            w_skid_vld_sig = 1'b1;
                            w_estado_sig   = S_HOLD;
                        end
                    end
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    w_ifid_sig     = r_skid;
                    w_ifid_vld_sig = 1'b1;
                    w_skid_vld_sig = 1'b0;
                    w_estado_sig   = S_FETCH;
                end
            end
            default: w_estado_sig = S_IDLE;
        endcase

        // Redirect wins over ack, stall and HOLD.
        if (w_redir) begin
            w_pc_sig       = w_dest;
            w_ifid_vld_sig = 1'b0;
            w_skid_vld_sig = 1'b0;
            w_estado_sig   = S_FETCH;
            if (imem_req && !imem_ack) begin
                w_squash_sig = 1'b1;
                if (!r_squash) w_sq_addr_sig = r_pc;
            end else begin
                w_squash_sig = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= S_IDLE;
            r_pc       <= PC_RESET;
            r_sq_addr  <= 32'd0;
            r_squash   <= 1'b0;
            r_ifid     <= '0;
            r_ifid_vld <= 1'b0;
            r_skid     <= '0;
            r_skid_vld <= 1'b0;
        end else begin
            r_estado   <= w_estado_sig;
            r_pc       <= w_pc_sig;
            r_sq_addr  <= w_sq_addr_sig;
            r_squash   <= w_squash_sig;
            r_ifid     <= w_ifid_sig;
            r_ifid_vld <= w_ifid_vld_sig;
            r_skid     <= w_skid_sig;
            r_skid_vld <= w_skid_vld_sig;
        end
    end

endmodule

// File: tb/tb_unidad_busqueda.sv
// Self-checking bench for unidad_busqueda: directed scenarios plus a randomized run
// against a queue-based model of the fetched-instruction stream.
module tb_unidad_busqueda;

    logic        clk;
    logic        rst_n;
    logic [1:0]  fuente_pc;
    logic [31:0] dir_rama, dir_salto, dir_reg;
    logic        stall;
    logic        imem_ack;
    logic        imem_req, id_valid, excepcion;
    logic [31:0] imem_addr, imem_rdata, id_instr, id_pc4;
    logic        wr_req, wr_valid, wr_exc;
    logic [31:0] wr_addr, wr_rdata, wr_instr, wr_pc4;

    int n_checks = 0;
    int n_errs   = 0;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    // Memory content: a scrambled image of the address, distinct per word.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_A5A5;
    endfunction

    assign imem_rdata = mem_f(imem_addr);
    assign wr_rdata   = mem_f(wr_addr);

    unidad_busqueda u_dut (
        .clk(clk), .rst_n(rst_n), .fuente_pc(fuente_pc),
        .dir_rama(dir_rama), .dir_salto(dir_salto), .dir_reg(dir_reg),
        .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
        .excepcion(excepcion)
    );

    unidad_busqueda #(.PC_RESET(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .fuente_pc(fuente_pc),
        .dir_rama(dir_rama), .dir_salto(dir_salto), .dir_reg(dir_reg),
        .stall(stall), .imem_req(wr_req), .imem_addr(wr_addr),
        .imem_ack(imem_ack), .imem_rdata(wr_rdata),
        .id_instr(wr_instr), .id_pc4(wr_pc4), .id_valid(wr_valid),
        .excepcion(wr_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: instructions fetched but not yet taken by decode, oldest first (at most 2).
    bit          m_run;
    logic [31:0] m_pc;
    bit          m_sq;
    logic [31:0] m_sq_addr;
    bit          m_exc;
    logic [63:0] m_q[$];

    function automatic logic [31:0] dest_f(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? 32'h8000_0180 : t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    function automatic logic [31:0] rnd_t();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
        return t;
    endfunction

    task automatic model_clear();
        m_run = 1'b0; m_pc = 32'd0; m_sq = 1'b0; m_sq_addr = 32'd0; m_exc = 1'b0;
        m_q.delete();
    endtask

    // Advance the model by one edge using the inputs now driven, then wait for that edge.
    task automatic tick();
        logic [31:0] t;
        bit          e_req;
        e_req = m_run && (m_q.size() < 2);
        if (fuente_pc != 2'b00) begin
            t = (fuente_pc == 2'b01) ? dir_rama : (fuente_pc == 2'b10) ? dir_salto : dir_reg;
            m_exc = MIS_EN && (t[1:0] != 2'b00);
            if (e_req && !imem_ack) begin
                if (!m_sq) m_sq_addr = m_pc;
                m_sq = 1'b1;
            end else begin
                m_sq = 1'b0;
            end
            m_pc = dest_f(t);
            m_q.delete();
        end else begin
            m_exc = 1'b0;
            if (m_q.size() != 0 && !stall) void'(m_q.pop_front());
            if (e_req && imem_ack) begin
                if (m_sq) m_sq = 1'b0;
                else begin
                    m_q.push_back({mem_f(m_pc), m_pc + 32'd4});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_run = 1'b1;
        @(posedge clk); #1;
    endtask

    // Leaves the bench at the first cycle after reset release (IDLE cycle).
    task automatic do_reset();
        rst_n = 1'b0; fuente_pc = 2'b00; dir_rama = 32'd0; dir_salto = 32'd0;
        dir_reg = 32'd0; stall = 1'b0; imem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ack = 1'b1; stall = 1'b0; fuente_pc = 2'b00;
        @(posedge clk); #1;
        n_checks++; if (imem_req !== 1'b0) begin n_errs++; $display("FAIL rst_req got %0b exp 0", imem_req); end
        n_checks++; if (imem_addr !== 32'd0) begin n_errs++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
        n_checks++; if (id_valid !== 1'b0) begin n_errs++; $display("FAIL rst_valid got %0b exp 0", id_valid); end
        n_checks++; if (id_instr !== 32'd0) begin n_errs++; $display("FAIL rst_instr got %h exp 0", id_instr); end
        n_checks++; if (id_pc4 !== 32'd0) begin n_errs++; $display("FAIL rst_pc4 got %h exp 0", id_pc4); end
        n_checks++; if (excepcion !== 1'b0) begin n_errs++; $display("FAIL rst_exc got %0b exp 0", excepcion); end
        n_checks++; if (wr_addr !== 32'hFFFF_FFFC) begin n_errs++; $display("FAIL rst_wrap_addr got %h exp fffffffc", wr_addr); end
        do_reset();
        imem_ack = 1'b1;
        n_checks++; if (imem_req !== 1'b0) begin n_errs++; $display("FAIL idle_req got %0b exp 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1) begin n_errs++; $display("FAIL first_req got %0b exp 1", imem_req); end
        n_checks++; if (imem_addr !== 32'd0) begin n_errs++; $display("FAIL first_addr got %h exp 0", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] ea;
        do_reset();
        imem_ack = 1'b1;
        for (int k = 0; k < 24; k++) begin
            if (k == 0) begin
                n_checks++; if (imem_req !== 1'b0) begin n_errs++; $display("FAIL strm_req0 got %0b exp 0", imem_req); end
            end else begin
                ea = 32'(4 * (k - 1));
                n_checks++; if (imem_req !== 1'b1) begin n_errs++; $display("FAIL strm_req k=%0d got %0b exp 1", k, imem_req); end
                n_checks++; if (imem_addr !== ea) begin n_errs++; $display("FAIL strm_addr k=%0d got %h exp %h", k, imem_addr, ea); end
            end
            if (k >= 2) begin
                ea = 32'(4 * (k - 2));
                n_checks++; if (id_valid !== 1'b1) begin n_errs++; $display("FAIL strm_valid k=%0d got %0b exp 1", k, id_valid); end
                n_checks++; if (id_instr !== mem_f(ea)) begin n_errs++; $display("FAIL strm_instr k=%0d got %h exp %h", k, id_instr, mem_f(ea)); end
                n_checks++; if (id_pc4 !== ea + 32'd4) begin n_errs++; $display("FAIL strm_pc4 k=%0d got %h exp %h", k, id_pc4, ea + 32'd4); end
            end
            if (k == 1) begin
                n_checks++; if (wr_addr !== 32'hFFFF_FFFC) begin n_errs++; $display("FAIL wrap_addr1 got %h exp fffffffc", wr_addr); end
            end
            if (k == 2) begin
                n_checks++; if (wr_addr !== 32'd0) begin n_errs++; $display("FAIL wrap_addr2 got %h exp 0", wr_addr); end
                n_checks++; if (wr_pc4 !== 32'd0) begin n_errs++; $display("FAIL wrap_pc4 got %h exp 0", wr_pc4); end
                n_checks++; if (wr_valid !== 1'b1) begin n_errs++; $display("FAIL wrap_valid got %0b exp 1", wr_valid); end
                n_checks++; if (wr_instr !== mem_f(32'hFFFF_FFFC)) begin n_errs++; $display("FAIL wrap_instr got %h exp %h", wr_instr, mem_f(32'hFFFF_FFFC)); end
            end
            tick();
        end
    endtask

    task automatic test_stall_skid();
        do_reset();
        imem_ack = 1'b1;
        tick(); tick();
        stall = 1'b1;
        tick();
        for (int k = 3; k <= 5; k++) begin
            n_checks++; if (imem_req !== 1'b0) begin n_errs++; $display("FAIL hold_req k=%0d got %0b exp 0", k, imem_req); end
            n_checks++; if (id_valid !== 1'b1) begin n_errs++; $display("FAIL hold_valid k=%0d got %0b exp 1", k, id_valid); end
            n_checks++; if (id_instr !== mem_f(32'd0)) begin n_errs++; $display("FAIL hold_instr k=%0d got %h exp %h", k, id_instr, mem_f(32'd0)); end
            n_checks++; if (id_pc4 !== 32'd4) begin n_errs++; $display("FAIL hold_pc4 k=%0d got %h exp 4", k, id_pc4); end
            if (k == 5) stall = 1'b0;
            tick();
        end
        n_checks++; if (id_instr !== mem_f(32'd4)) begin n_errs++; $display("FAIL skid_instr got %h exp %h", id_instr, mem_f(32'd4)); end
        n_checks++; if (id_pc4 !== 32'd8) begin n_errs++; $display("FAIL skid_pc4 got %h exp 8", id_pc4); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin n_errs++; $display("FAIL skid_next got %0b/%h exp 1/8", imem_req, imem_addr); end
        imem_ack = 1'b0;
        tick();
        n_checks++; if (id_valid !== 1'b0) begin n_errs++; $display("FAIL skid_drain got %0b exp 0", id_valid); end
    endtask

    task automatic test_squash();
        do_reset();
        imem_ack = 1'b1;
        repeat (5) tick();
        n_checks++; if (imem_addr !== 32'h10) begin n_errs++; $display("FAIL sq_pre_addr got %h exp 10", imem_addr); end
        imem_ack = 1'b0; fuente_pc = 2'b01; dir_rama = 32'h100;
        tick();
        fuente_pc = 2'b00;
        for (int k = 6; k <= 7; k++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_errs++; $display("FAIL sq_hold k=%0d got %0b/%h exp 1/10", k, imem_req, imem_addr); end
            n_checks++; if (id_valid !== 1'b0) begin n_errs++; $display("FAIL sq_valid k=%0d got %0b exp 0", k, id_valid); end
            imem_ack = (k == 7);
            tick();
        end
        n_checks++; if (imem_addr !== 32'h100) begin n_errs++; $display("FAIL sq_new_addr got %h exp 100", imem_addr); end
        n_checks++; if (id_valid !== 1'b0) begin n_errs++; $display("FAIL sq_discard got %0b exp 0", id_valid); end
        imem_ack = 1'b0;
        tick();
        n_checks++; if (id_valid !== 1'b0) begin n_errs++; $display("FAIL sq_wait got %0b exp 0", id_valid); end
        imem_ack = 1'b1;
        tick();
        n_checks++; if (id_valid !== 1'b1 || id_instr !== mem_f(32'h100)) begin n_errs++; $display("FAIL sq_instr got %0b/%h exp 1/%h", id_valid, id_instr, mem_f(32'h100)); end
        n_checks++; if (id_pc4 !== 32'h104) begin n_errs++; $display("FAIL sq_pc4 got %h exp 104", id_pc4); end
    endtask

    task automatic test_flush();
        do_reset();
        imem_ack = 1'b1;
        tick(); tick();
        stall = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0 || id_valid !== 1'b1) begin n_errs++; $display("FAIL fl_full got %0b/%0b exp 0/1", imem_req, id_valid); end
        fuente_pc = 2'b11; dir_reg = 32'h40;
        tick();
        fuente_pc = 2'b00;
        n_checks++; if (id_valid !== 1'b0) begin n_errs++; $display("FAIL fl_valid got %0b exp 0", id_valid); end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_errs++; $display("FAIL fl_addr got %0b/%h exp 1/40", imem_req, imem_addr); end
        tick();
        n_checks++; if (id_valid !== 1'b1 || id_instr !== mem_f(32'h40) || id_pc4 !== 32'h44) begin n_errs++; $display("FAIL fl_instr got %0b/%h/%h exp 1/%h/44", id_valid, id_instr, id_pc4, mem_f(32'h40)); end
        stall = 1'b0;
    endtask

    task automatic test_misalign();
        logic [31:0] ea;
        ea = MIS_EN ? 32'h8000_0180 : 32'h0000_0100;
        do_reset();
        imem_ack = 1'b1;
        tick();
        fuente_pc = 2'b10; dir_salto = 32'h102;
        tick();
        fuente_pc = 2'b00; imem_ack = 1'b0;
        n_checks++; if (excepcion !== MIS_EN) begin n_errs++; $display("FAIL mis_exc got %0b exp %0b", excepcion, MIS_EN); end
        n_checks++; if (imem_addr !== ea) begin n_errs++; $display("FAIL mis_addr got %h exp %h", imem_addr, ea); end
        n_checks++; if (id_valid !== 1'b0) begin n_errs++; $display("FAIL mis_valid got %0b exp 0", id_valid); end
        tick();
        n_checks++; if (excepcion !== 1'b0) begin n_errs++; $display("FAIL mis_pulse got %0b exp 0", excepcion); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_ack = 1'b1;
        tick(); tick();
        imem_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd0) begin n_errs++; $display("FAIL mid_req got %0b/%h exp 0/0", imem_req, imem_addr); end
        n_checks++; if (id_valid !== 1'b0 || id_instr !== 32'd0 || id_pc4 !== 32'd0) begin n_errs++; $display("FAIL mid_ifid got %0b/%h/%h exp 0/0/0", id_valid, id_instr, id_pc4); end
        imem_ack = 1'b1;
        @(posedge clk); #1;
        model_clear();
        rst_n = 1'b1;
        n_checks++; if (imem_req !== 1'b0) begin n_errs++; $display("FAIL late_ack_req got %0b exp 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || id_valid !== 1'b0) begin n_errs++; $display("FAIL late_ack got %0b/%h/%0b exp 1/0/0", imem_req, imem_addr, id_valid); end
        tick();
        n_checks++; if (id_valid !== 1'b1 || id_instr !== mem_f(32'd0) || id_pc4 !== 32'd4) begin n_errs++; $display("FAIL mid_restart got %0b/%h/%h", id_valid, id_instr, id_pc4); end
    endtask

    task automatic test_random();
        bit          e_req;
        logic [31:0] ea;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            e_req = m_run && (m_q.size() < 2);
            ea    = m_sq ? m_sq_addr : m_pc;
            n_checks++; if (imem_req !== e_req) begin n_errs++; $display("FAIL rnd_req c=%0d got %0b exp %0b", c, imem_req, e_req); end
            if (e_req) begin
                n_checks++; if (imem_addr !== ea) begin n_errs++; $display("FAIL rnd_addr c=%0d got %h exp %h", c, imem_addr, ea); end
            end
            n_checks++; if (id_valid !== (m_q.size() != 0)) begin n_errs++; $display("FAIL rnd_valid c=%0d got %0b exp %0b", c, id_valid, m_q.size() != 0); end
            if (m_q.size() != 0) begin
                n_checks++; if ({id_instr, id_pc4} !== m_q[0]) begin n_errs++; $display("FAIL rnd_ifid c=%0d got %h/%h exp %h", c, id_instr, id_pc4, m_q[0]); end
            end
            n_checks++; if (excepcion !== m_exc) begin n_errs++; $display("FAIL rnd_exc c=%0d got %0b exp %0b", c, excepcion, m_exc); end
            stall     = ($urandom_range(0, 99) < 40);
            imem_ack  = ($urandom_range(0, 99) < 60);
            fuente_pc = ($urandom_range(0, 99) < 12) ? 2'($urandom_range(1, 3)) : 2'b00;
            dir_rama  = rnd_t();
            dir_salto = rnd_t();
            dir_reg   = rnd_t();
            tick();
        end
        fuente_pc = 2'b00;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall_skid();
        test_squash();
        test_flush();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
